// File: rtl/serial_wb_slave.sv
// Wishbone pipelined slave that tunnels each request as a byte-serial command frame
// and completes it from a byte-serial response, with a response timeout.
module serial_wb_slave #(
    parameter int unsigned BYTES          = 2,
    parameter int unsigned ADDR_BITS      = 23,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic [ADDR_BITS-1:0] s_wb_addr,
    input  logic [BYTES*8-1:0]   s_wb_dat_m2s,
    output logic [BYTES*8-1:0]   s_wb_dat_s2m,
    input  logic                 s_wb_we,
    input  logic [BYTES-1:0]     s_wb_sel,
    input  logic                 s_wb_stb,
    input  logic                 s_wb_cyc,
    output logic                 s_wb_ack,
    output logic                 s_wb_err,
    output logic                 s_wb_stall,
    input  logic                 axis_o_tready,
    output logic                 axis_o_tvalid,
    output logic                 axis_o_tlast,
    output logic [7:0]           axis_o_tdata,
    output logic                 axis_i_tready,
    input  logic                 axis_i_tvalid,
    input  logic                 axis_i_tlast,
    input  logic [7:0]           axis_i_tdata
);

    localparam int unsigned AddrBytes = (ADDR_BITS + 7) / 8;
    localparam int unsigned DW        = BYTES * 8;
    localparam int unsigned AW        = AddrBytes * 8;
    localparam int unsigned TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] AddrLast   = 8'(AddrBytes - 1);
    localparam logic [7:0] DataLast   = 8'(BYTES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSendOp,
        StSendAddr,
        StSendData,
        StWaitResp
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdat_q, wdat_d;
    logic [DW-1:0]   shreg_q, shreg_d;
    logic [DW-1:0]   rdat_q, rdat_d;
    logic            we_q, we_d;
    logic            alive_q, alive_d;
    logic [7:0]      idx_q, idx_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic            rdy_q;
    logic            accept, o_hs, i_hs;
    logic [DW-1:0]   shifted;
    logic            unused_ok;

    assign unused_ok = ^{s_wb_sel, axis_i_tlast};

    // rdy_q keeps the slave quiet until the first edge after reset releases.
    assign s_wb_stall    = !rdy_q || (state_q != StIdle) || ack_q || err_q;
    assign axis_i_tready = rdy_q && ((state_q == StIdle) || (state_q == StWaitResp));
    assign accept        = s_wb_stb && s_wb_cyc && !s_wb_stall;
    assign o_hs          = axis_o_tvalid && axis_o_tready;
    assign i_hs          = axis_i_tvalid && axis_i_tready;
    assign s_wb_dat_s2m  = rdat_q;
    assign s_wb_ack      = ack_q;
    assign s_wb_err      = err_q;

    always_comb begin
        shifted      = shreg_q << 8;
        shifted[7:0] = axis_i_tdata;
    end

    always_comb begin
        axis_o_tvalid = 1'b0;
        axis_o_tlast  = 1'b0;
        axis_o_tdata  = 8'h00;
        unique case (state_q)
            StSendOp: begin
                axis_o_tvalid = 1'b1;
                axis_o_tdata  = {7'b0, we_q};
            end
            StSendAddr: begin
                axis_o_tvalid = 1'b1;
                axis_o_tdata  = addr_q[{idx_q, 3'b000} +: 8];
                axis_o_tlast  = !we_q && (idx_q == 8'd0);
            end
            StSendData: begin
                axis_o_tvalid = 1'b1;
                axis_o_tdata  = wdat_q[{idx_q, 3'b000} +: 8];
                axis_o_tlast  = (idx_q == 8'd0);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        shreg_d = shreg_q;
        rdat_d  = rdat_q;
        we_d    = we_q;
        idx_d   = idx_q;
        tmo_d   = '0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        // A master that drops cyc mid-transaction still gets the frame finished,
        // but no completion is reported.
        alive_d = (state_q == StIdle) ? alive_q : (alive_q && s_wb_cyc);

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d                 = StSendOp;
                    addr_d                  = '0;
                    addr_d[ADDR_BITS-1:0]   = s_wb_addr;
                    wdat_d                  = s_wb_dat_m2s;
                    we_d                    = s_wb_we;
                    alive_d                 = 1'b1;
                end
            end
            StSendOp: begin
                if (o_hs) begin
                    state_d = StSendAddr;
                    idx_d   = AddrLast;
                end
            end
            StSendAddr: begin
                if (o_hs) begin
                    if (idx_q == 8'd0) begin
                        state_d = we_q ? StSendData : StWaitResp;
                        idx_d   = DataLast;
                    end else begin
                        idx_d = idx_q - 8'd1;
                    end
                end
            end
            StSendData: begin
                if (o_hs) begin
                    if (idx_q == 8'd0) begin
                        state_d = StWaitResp;
                        idx_d   = 8'd0;
                    end else begin
                        idx_d = idx_q - 8'd1;
                    end
                end
            end
            StWaitResp: begin
                if (i_hs) begin
                    shreg_d = shifted;
                    if (idx_q == 8'd0) begin
                        state_d = StIdle;
                        ack_d   = alive_d;
                        if (!we_q) rdat_d = shifted;
                    end else begin
                        idx_d = idx_q - 8'd1;
                    end
                end else if (tmo_q == TmoLast) begin
                    state_d = StIdle;
                    err_d   = alive_d;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdat_q  <= '0;
            shreg_q <= '0;
            rdat_q  <= '0;
            we_q    <= 1'b0;
            alive_q <= 1'b0;
            idx_q   <= 8'd0;
            tmo_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            shreg_q <= shreg_d;
            rdat_q  <= rdat_d;
            we_q    <= we_d;
            alive_q <= alive_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdy_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_wb_slave.sv
// Directed bench for serial_wb_slave: frame encoding, response handling, timeout,
// stall/backpressure and asynchronous reset behaviour.
module tb_serial_wb_slave;

    logic        clk = 1'b0;
    logic        areset;
    logic [22:0] s_wb_addr;
    logic [15:0] s_wb_dat_m2s;
    logic [15:0] s_wb_dat_s2m;
    logic        s_wb_we;
    logic [1:0]  s_wb_sel;
    logic        s_wb_stb;
    logic        s_wb_cyc;
    logic        s_wb_ack;
    logic        s_wb_err;
    logic        s_wb_stall;
    logic        axis_o_tready;
    logic        axis_o_tvalid;
    logic        axis_o_tlast;
    logic [7:0]  axis_o_tdata;
    logic        axis_i_tready;
    logic        axis_i_tvalid;
    logic        axis_i_tlast;
    logic [7:0]  axis_i_tdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_wb_slave #(
        .BYTES         (2),
        .ADDR_BITS     (23),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk          (clk),
        .areset       (areset),
        .s_wb_addr    (s_wb_addr),
        .s_wb_dat_m2s (s_wb_dat_m2s),
        .s_wb_dat_s2m (s_wb_dat_s2m),
        .s_wb_we      (s_wb_we),
        .s_wb_sel     (s_wb_sel),
        .s_wb_stb     (s_wb_stb),
        .s_wb_cyc     (s_wb_cyc),
        .s_wb_ack     (s_wb_ack),
        .s_wb_err     (s_wb_err),
        .s_wb_stall   (s_wb_stall),
        .axis_o_tready(axis_o_tready),
        .axis_o_tvalid(axis_o_tvalid),
        .axis_o_tlast (axis_o_tlast),
        .axis_o_tdata (axis_o_tdata),
        .axis_i_tready(axis_i_tready),
        .axis_i_tvalid(axis_i_tvalid),
        .axis_i_tlast (axis_i_tlast),
        .axis_i_tdata (axis_i_tdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_req(input logic [22:0] addr, input logic [15:0] dat, input logic we);
        s_wb_addr    = addr;
        s_wb_dat_m2s = dat;
        s_wb_we      = we;
        s_wb_cyc     = 1'b1;
        s_wb_stb     = 1'b1;
        tick();
        s_wb_stb = 1'b0;
    endtask

    // Collect n command bytes (exp holds them MSB first), optionally toggling tready.
    task automatic send_expect(input string tag, input logic [63:0] exp, input int n,
                               input bit toggle);
        int   got = 0;
        int   cnt = 0;
        bit   holding = 1'b0;
        bit   rdy = !toggle;
        logic [7:0] held = 8'h00;
        while (got < n && cnt < 64) begin
            axis_o_tready = rdy;
            if (holding) chk({tag, "_stable"}, {24'h0, axis_o_tdata}, {24'h0, held});
            if (axis_o_tvalid && rdy) begin
                chk($sformatf("%s_b%0d", tag, got), {24'h0, axis_o_tdata},
                    {24'h0, exp[(n-1-got)*8 +: 8]});
                chk($sformatf("%s_last%0d", tag, got), {31'h0, axis_o_tlast},
                    {31'h0, got == n - 1});
                got++;
                holding = 1'b0;
            end else if (axis_o_tvalid) begin
                held    = axis_o_tdata;
                holding = 1'b1;
            end
            tick();
            cnt++;
            if (toggle) rdy = !rdy;
        end
        axis_o_tready = 1'b1;
        if (got < n) chk({tag, "_frame_timeout"}, got, n);
    endtask

    task automatic respond(input string tag, input logic [31:0] bytes, input int n);
        for (int i = 0; i < n; i++) begin
            axis_i_tvalid = 1'b1;
            axis_i_tdata  = bytes[(n-1-i)*8 +: 8];
            chk({tag, "_irdy"}, {31'h0, axis_i_tready}, 32'h1);
            tick();
        end
        axis_i_tvalid = 1'b0;
    endtask

    task automatic expect_ack(input string tag, input logic [15:0] dat, input bit rd);
        chk({tag, "_ack"}, {31'h0, s_wb_ack}, 32'h1);
        chk({tag, "_err"}, {31'h0, s_wb_err}, 32'h0);
        chk({tag, "_stall_ack"}, {31'h0, s_wb_stall}, 32'h1);
        if (rd) chk({tag, "_dat"}, {16'h0, s_wb_dat_s2m}, {16'h0, dat});
        tick();
        chk({tag, "_ack_once"}, {31'h0, s_wb_ack}, 32'h0);
        chk({tag, "_stall_idle"}, {31'h0, s_wb_stall}, 32'h0);
    endtask

    initial begin
        int n;
        bit seen;
        bit ack_seen;
        areset        = 1'b1;
        s_wb_addr     = '0;
        s_wb_dat_m2s  = '0;
        s_wb_we       = 1'b0;
        s_wb_sel      = 2'b11;
        s_wb_stb      = 1'b0;
        s_wb_cyc      = 1'b0;
        axis_o_tready = 1'b1;
        axis_i_tvalid = 1'b0;
        axis_i_tlast  = 1'b0;
        axis_i_tdata  = 8'h00;

        // Reset state
        #2;
        chk("rst_stall", {31'h0, s_wb_stall}, 32'h1);
        chk("rst_tvalid", {31'h0, axis_o_tvalid}, 32'h0);
        chk("rst_tlast", {31'h0, axis_o_tlast}, 32'h0);
        chk("rst_tdata", {24'h0, axis_o_tdata}, 32'h0);
        chk("rst_irdy", {31'h0, axis_i_tready}, 32'h0);
        chk("rst_dat", {16'h0, s_wb_dat_s2m}, 32'h0);
        chk("rst_ack", {31'h0, s_wb_ack}, 32'h0);
        chk("rst_err", {31'h0, s_wb_err}, 32'h0);
        tick();
        tick();
        areset = 1'b0;
        chk("rel_stall_hold", {31'h0, s_wb_stall}, 32'h1);
        tick();
        chk("rel_stall", {31'h0, s_wb_stall}, 32'h0);
        chk("rel_irdy", {31'h0, axis_i_tready}, 32'h1);

        // Write 0x012345 <- 0xBEEF
        wb_req(23'h012345, 16'hBEEF, 1'b1);
        chk("wr_stall_busy", {31'h0, s_wb_stall}, 32'h1);
        send_expect("wr", 64'h0001_0123_45BE_EF, 6, 1'b0);
        respond("wr", 32'h00, 1);
        expect_ack("wr", 16'h0, 1'b0);

        // Read 0x000010 -> 0xABCD
        wb_req(23'h000010, 16'h0, 1'b0);
        send_expect("rd", 64'h0000_0010, 4, 1'b0);
        respond("rd", 32'hABCD, 2);
        expect_ack("rd", 16'hABCD, 1'b1);

        // Read with tready toggling
        wb_req(23'h456789, 16'h0, 1'b0);
        send_expect("tog", 64'h0045_6789, 4, 1'b1);
        respond("tog", 32'h1234, 2);
        expect_ack("tog", 16'h1234, 1'b1);

        // Timeout: read with no response
        wb_req(23'h000020, 16'h0, 1'b0);
        send_expect("tmo", 64'h0000_0020, 4, 1'b0);
        n = 0;
        seen = 1'b0;
        ack_seen = 1'b0;
        while (!seen && n < 40) begin
            if (s_wb_ack) ack_seen = 1'b1;
            if (s_wb_err) begin
                seen = 1'b1;
            end else begin
                tick();
                n++;
            end
        end
        chk("tmo_cycles", n, 16);
        chk("tmo_noack", {31'h0, ack_seen}, 32'h0);
        chk("tmo_stall", {31'h0, s_wb_stall}, 32'h1);
        tick();
        chk("tmo_err_once", {31'h0, s_wb_err}, 32'h0);
        axis_i_tvalid = 1'b1;
        axis_i_tdata  = 8'h55;
        chk("stray_irdy", {31'h0, axis_i_tready}, 32'h1);
        tick();
        axis_i_tvalid = 1'b0;
        tick();
        chk("stray_ack", {31'h0, s_wb_ack}, 32'h0);
        chk("stray_dat", {16'h0, s_wb_dat_s2m}, 32'h1234);
        chk("stray_stall", {31'h0, s_wb_stall}, 32'h0);

        // Second request held off while first is active
        wb_req(23'h000001, 16'h1111, 1'b1);
        s_wb_addr    = 23'h000002;
        s_wb_dat_m2s = 16'h2222;
        s_wb_we      = 1'b0;
        s_wb_stb     = 1'b1;
        chk("hold_stall", {31'h0, s_wb_stall}, 32'h1);
        send_expect("holdA", 64'h0100_0001_1111, 6, 1'b0);
        respond("holdA", 32'h00, 1);
        expect_ack("holdA", 16'h0, 1'b0);
        tick();
        s_wb_stb = 1'b0;
        send_expect("holdB", 64'h0000_0002, 4, 1'b0);
        respond("holdB", 32'h9876, 2);
        expect_ack("holdB", 16'h9876, 1'b1);

        // Reset during SEND_ADDR
        wb_req(23'h000033, 16'h0, 1'b0);
        axis_o_tready = 1'b1;
        tick();
        chk("ar_sending", {31'h0, axis_o_tvalid}, 32'h1);
        areset = 1'b1;
        #1;
        chk("ar_tvalid", {31'h0, axis_o_tvalid}, 32'h0);
        chk("ar_tdata", {24'h0, axis_o_tdata}, 32'h0);
        chk("ar_stall", {31'h0, s_wb_stall}, 32'h1);
        chk("ar_irdy", {31'h0, axis_i_tready}, 32'h0);
        chk("ar_dat", {16'h0, s_wb_dat_s2m}, 32'h0);
        tick();
        areset = 1'b0;
        tick();
        chk("ar_ack", {31'h0, s_wb_ack}, 32'h0);
        chk("ar_idle_tvalid", {31'h0, axis_o_tvalid}, 32'h0);
        chk("ar_rel_stall", {31'h0, s_wb_stall}, 32'h0);
        wb_req(23'h00ABCD, 16'h0102, 1'b1);
        send_expect("ar_wr", 64'h0100_ABCD_0102, 6, 1'b0);
        respond("ar_wr", 32'h77, 1);
        expect_ack("ar_wr", 16'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_wb_slave.md
SERIAL_WB_SLAVE -- requirements
Module: serial_wb_slave

Interface
REQ-001 SHALL have parameter BYTES, default 2, wishbone data width in bytes.
REQ-002 SHALL have parameter ADDR_BITS, default 23, wishbone address width; ADDR_BYTES = ceil(ADDR_BITS/8).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535, maximum idle cycles between response bytes.
REQ-004 SHALL have one clock and an asynchronous active-high reset:
- clk  in  1  sole clock, rising edge
- areset  in  1  asynchronous, active-high
REQ-005 SHALL have the following wishbone pipelined slave ports:
- s_wb_addr  in  ADDR_BITS  word address
- s_wb_dat_m2s  in  BYTES*8  write data
- s_wb_dat_s2m  out  BYTES*8  read data
- s_wb_we  in  1  write enable
- s_wb_sel  in  BYTES  ignored
- s_wb_stb  in  1  strobe
- s_wb_cyc  in  1  cycle
- s_wb_ack  out  1  completion
- s_wb_err  out  1  timeout completion
- s_wb_stall  out  1  not accepting
REQ-006 SHALL have the following command byte stream ports:
- axis_o_tready  in  1
- axis_o_tvalid  out  1
- axis_o_tlast  out  1  final frame byte
- axis_o_tdata  out  8
REQ-007 SHALL have the following response byte stream ports:
- axis_i_tready  out  1
- axis_i_tvalid  in  1
- axis_i_tlast  in  1  ignored
- axis_i_tdata  in  8

Function
REQ-008 SHALL encode each accepted request as a command frame: opcode byte (0x01 write, 0x00 read), ADDR_BYTES address bytes MSB first (zero-extended), then for writes BYTES data bytes MSB first.
REQ-009 SHALL expect a response of one byte for a write (value ignored) or BYTES bytes MSB first for a read.
REQ-010 SHALL implement states IDLE, SEND_OP, SEND_ADDR, SEND_DATA, WAIT_RESP.
REQ-011 SHALL hold s_wb_stall=0 only in IDLE; an accept is stb&cyc&!stall; at most one transaction is outstanding.
REQ-012 SHALL on accept latch addr/data/we and enter SEND_OP on the next cycle.
REQ-013 SHALL advance one byte per cycle when axis_o_tvalid&axis_o_tready; tdata/tvalid/tlast SHALL remain stable while tready=0.
REQ-014 SHALL assert axis_o_tlast on the last address byte (read) or last data byte (write); SEND_DATA SHALL be skipped for reads.
REQ-015 SHALL enter WAIT_RESP after the tlast byte handshakes; axis_i_tready=1 in WAIT_RESP, shifting each byte into s_wb_dat_s2m from the LSB end.
REQ-016 SHALL pulse s_wb_ack for exactly one cycle, registered, the cycle after the final response byte handshakes, and return to IDLE in that cycle; s_wb_dat_s2m SHALL be valid during ack and held until the next read completes.
REQ-017 SHALL count cycles in WAIT_RESP, cleared on each response byte; on reaching TIMEOUT_CYCLES it SHALL pulse s_wb_err for one cycle (no ack) and return to IDLE.
REQ-018 SHALL keep axis_i_tready=1 in IDLE and discard stray bytes (late responses after timeout).
REQ-019 SHALL keep axis_i_tready=0 and not count timeout in SEND_* states.
REQ-020 SHALL, if s_wb_cyc falls mid-transaction, complete the frame and response but suppress ack/err.
REQ-021 SHALL NOT accept a new request in the IDLE-return cycle of ack/err (stall held 1 in that cycle).

Reset
REQ-022 SHALL on areset immediately force: state IDLE, s_wb_ack=0, s_wb_err=0, s_wb_stall=1, axis_o_tvalid=0, axis_o_tlast=0, axis_o_tdata=0, axis_i_tready=0, s_wb_dat_s2m=0, timeout counter 0.
REQ-023 SHALL release stall and axis_i_tready on the first clock edge after areset deasserts; reset mid-frame SHALL abandon the frame with no ack.

Verification
REQ-024 Write addr=0x012345 data=0xBEEF, tready=1 -> bytes 01 01 23 45 BE EF, tlast on EF; response byte 00 -> one-cycle ack.
REQ-025 Read addr=0x000010, response AB CD -> bytes 00 00 00 10 (tlast on 10), ack with dat_s2m=0xABCD.
REQ-026 Read with tready toggling 1/0 each cycle -> tdata stable while tready=0, same 4 bytes, correct order.
REQ-027 TIMEOUT_CYCLES=16, read with no response -> err pulse 16 cycles into WAIT_RESP, no ack; later byte 0x55 discarded in IDLE.
REQ-028 Second stb during active transaction -> stall=1, request held, issued only after first ack.
REQ-029 areset asserted during SEND_ADDR -> tvalid=0 same cycle, no ack, next request frames correctly.
